// File: rtl/fpu_ss_predecode_queue.sv
// Predecodes RISC-V F/D instruction words into offload flags and queues them with their IDs.
// Latency: 1 cycle from request handshake to response. There is no bypass path to the outputs.
// Backpressure: req_ready_o drops when the queue is full, and the head entry is held until rsp_ready_i.
module fpu_ss_predecode_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RVD       = 0,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_instr_i,
    input  logic [ID_WIDTH-1:0]  req_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_accept_o,
    output logic                 rsp_writeback_o,
    output logic                 rsp_is_mem_op_o,
    output logic [2:0]           rsp_use_rs_o,
    output logic [ID_WIDTH-1:0]  rsp_id_o,
    output logic [CNT_WIDTH-1:0] accept_cnt_o,
    output logic [CNT_WIDTH-1:0] reject_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        CLS_UNKNOWN,
        CLS_COMPUTE,
        CLS_F2I,
        CLS_I2F,
        CLS_MEM,
        CLS_CSR
    } cls_e;

    typedef struct packed {
        logic                accept;
        logic                writeback;
        logic                is_mem;
        logic [2:0]          use_rs;
        logic [ID_WIDTH-1:0] id;
    } entry_t;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  funct5;
    logic [1:0]  fmt;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic        fmt_ok;
    logic        mem_width_ok;
    logic        csr_is_fp;
    logic        unused_instr_bits;

    assign opcode   = req_instr_i[6:0];
    assign funct5   = req_instr_i[31:27];
    assign fmt      = req_instr_i[26:25];
    assign rs2      = req_instr_i[24:20];
    assign funct3   = req_instr_i[14:12];
    assign csr_addr = req_instr_i[31:20];

    // Double-precision formats and widths only exist when RVD is enabled.
    assign fmt_ok       = (fmt == 2'b00) || ((RVD != 0) && (fmt == 2'b01));
    assign mem_width_ok = (funct3 == 3'b010) || ((RVD != 0) && (funct3 == 3'b011));
    assign csr_is_fp    = (csr_addr == 12'h001) || (csr_addr == 12'h002) || (csr_addr == 12'h003);

    // rs1 and rd never influence classification.
    assign unused_instr_bits = ^{req_instr_i[19:15], req_instr_i[11:7]};

    cls_e   dec_cls;
    entry_t dec_entry;

    // Classify the incoming instruction word.
    always_comb begin
        dec_cls = CLS_UNKNOWN;
        unique case (opcode)
            OPC_LOAD_FP, OPC_STORE_FP: begin
                if (mem_width_ok) dec_cls = CLS_MEM;
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                if (fmt_ok) dec_cls = CLS_COMPUTE;
            end
            OPC_OP_FP: begin
                if (fmt_ok) begin
                    unique case (funct5)
                        5'b00000, 5'b00001, 5'b00010, 5'b00011: dec_cls = CLS_COMPUTE;
                        5'b01011: if (rs2 == 5'd0) dec_cls = CLS_COMPUTE;
                        5'b00100: if (funct3 <= 3'b010) dec_cls = CLS_COMPUTE;
                        5'b00101: if (funct3 <= 3'b001) dec_cls = CLS_COMPUTE;
                        5'b10100: if (funct3 <= 3'b010) dec_cls = CLS_F2I;
                        5'b11100: if ((rs2 == 5'd0) && (funct3 <= 3'b001)) dec_cls = CLS_F2I;
                        5'b11000: if (rs2[4:1] == 4'd0) dec_cls = CLS_F2I;
                        5'b11010: if (rs2[4:1] == 4'd0) dec_cls = CLS_I2F;
                        5'b11110: if ((rs2 == 5'd0) && (funct3 == 3'b000)) dec_cls = CLS_I2F;
                        default: dec_cls = CLS_UNKNOWN;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                if (((funct3 == 3'b001) || (funct3 == 3'b010)) && csr_is_fp) begin
                    dec_cls = CLS_CSR;
                end else if ((funct3 == 3'b101) &&
                             ((csr_addr == 12'h001) || (csr_addr == 12'h002))) begin
                    // Immediate writes to frm/fflags only return the old value to the integer side.
                    dec_cls = CLS_F2I;
                end
            end
            default: dec_cls = CLS_UNKNOWN;
        endcase
    end

    // Translate the class into the flag set stored in the queue.
    always_comb begin
        dec_entry           = '0;
        dec_entry.id        = req_id_i;
        unique case (dec_cls)
            CLS_COMPUTE: dec_entry.accept = 1'b1;
            CLS_F2I: begin
                dec_entry.accept    = 1'b1;
                dec_entry.writeback = 1'b1;
            end
            CLS_I2F: begin
                dec_entry.accept = 1'b1;
                dec_entry.use_rs = 3'b001;
            end
            CLS_MEM: begin
                dec_entry.accept = 1'b1;
                dec_entry.is_mem = 1'b1;
                dec_entry.use_rs = 3'b001;
            end
            CLS_CSR: begin
                dec_entry.accept    = 1'b1;
                dec_entry.writeback = 1'b1;
                dec_entry.use_rs    = 3'b001;
            end
            default: dec_entry.accept = 1'b0;
        endcase
    end

    // Queue state
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               full, empty;
    logic               push, pop;

    assign full        = (occ_q == OCC_W'(DEPTH));
    assign empty       = (occ_q == '0);
    assign req_ready_o = !full;
    assign rsp_valid_o = !empty;

    // A flush cancels both the handshake write and the head retirement of its cycle.
    assign push = req_valid_i && req_ready_o && !flush_i;
    assign pop  = rsp_valid_o && rsp_ready_i && !flush_i;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      occ_d = occ_q + OCC_W'(1);
            else if (pop && !push) occ_d = occ_q - OCC_W'(1);
        end
    end

    // Pointer and occupancy registers; reset overrides flush, push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage is written on a handshake; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem_q[wr_ptr_q] <= dec_entry;
    end

    entry_t head;
    assign head            = mem_q[rd_ptr_q];
    assign rsp_accept_o    = head.accept;
    assign rsp_writeback_o = head.writeback;
    assign rsp_is_mem_op_o = head.is_mem;
    assign rsp_use_rs_o    = head.use_rs;
    assign rsp_id_o        = head.id;

    // Saturating statistics; only reset clears them, flush leaves them alone.
    logic [CNT_WIDTH-1:0] accept_cnt_q;
    logic [CNT_WIDTH-1:0] reject_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            accept_cnt_q <= '0;
            reject_cnt_q <= '0;
        end else if (push) begin
            if (dec_entry.accept) begin
                if (accept_cnt_q != '1) accept_cnt_q <= accept_cnt_q + CNT_WIDTH'(1);
            end else begin
                if (reject_cnt_q != '1) reject_cnt_q <= reject_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign accept_cnt_o = accept_cnt_q;
    assign reject_cnt_o = reject_cnt_q;

endmodule
